// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial 1011 detector and its downstream event logger.
// Holds default counter widths and the detector state encoding so both blocks
// agree on one definition.
package seq_det_pkg;

    localparam int unsigned POS_W_DEF = 16;  // bit-position / timestamp width
    localparam int unsigned CNT_W_DEF = 16;  // total match counter width

    // Detector states: S0 idle, S1 saw 1, S2 saw 10, S3 saw 101.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3
    } det_state_e;

endpackage

// File: rtl/seq_match_event_logger_if.sv
// Bundle of the event logger's data-path signals.
//   match_in, clear, rd_ready            : driven by the producer/consumer side (master)
//   rd_valid, rd_pos, fifo_level,
//   match_count, overflow                : driven by the logger (slave)
interface seq_match_event_logger_if #(
    parameter int unsigned POS_W = 16,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             match_in;
    logic             clear;
    logic             rd_ready;
    logic             rd_valid;
    logic [POS_W-1:0] rd_pos;
    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] match_count;
    logic             overflow;

    modport master (
        output match_in, clear, rd_ready,
        input  rd_valid, rd_pos, fifo_level, match_count, overflow
    );

    modport slave (
        input  match_in, clear, rd_ready,
        output rd_valid, rd_pos, fifo_level, match_count, overflow
    );
endinterface

// File: rtl/evt_fifo.sv
// Small synchronous FIFO for logged match positions.
// Ports:
//   clk, reset (async, active-high), clear (sync)
//   push/wdata : write request; ignored when full unless a pop happens the same cycle
//   pop        : read request; ignored when empty
//   rdata      : head entry, read straight from the storage registers
//   full/empty/level : occupancy, level = write pointer minus read pointer
module evt_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + LW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_match_event_logger.sv
// Timestamps each detector match pulse with a free-running bit-position counter
// and buffers the positions in a FIFO drained through a valid/ready read port.
// Ports:
//   clk   : rising-edge clock, one cycle per serial bit
//   reset : asynchronous, active-high
//   bus   : slave side of seq_match_event_logger_if
//           in : match_in, clear (sync clear of all state), rd_ready
//           out: rd_valid, rd_pos (head), fifo_level, match_count (saturating),
//                overflow (sticky drop flag)
module seq_match_event_logger
    import seq_det_pkg::*;
#(
    parameter int unsigned POS_W = POS_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input logic                      clk,
    input logic                      reset,
    seq_match_event_logger_if.slave  bus
);
    logic [POS_W-1:0] pos_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push_req;
    logic             pop_req;
    logic             drop;

    // clear wins over both a match and a pop in the same cycle.
    assign push_req = bus.match_in && !bus.clear;
    assign pop_req  = bus.rd_ready && !fifo_empty && !bus.clear;
    assign drop     = push_req && fifo_full && !pop_req;

    evt_fifo #(
        .WIDTH (POS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .push  (push_req),
        .pop   (pop_req),
        .wdata (pos_q),
        .rdata (bus.rd_pos),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.clear) begin
            pos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pos_q <= pos_q + POS_W'(1);
            // Dropped matches still count; hold at all-ones.
            if (bus.match_in && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.rd_valid    = !fifo_empty;
    assign bus.match_count = cnt_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_match_event_logger.sv
// Self-checking bench: two logger instances (wide defaults and a narrow 4-bit
// position / 3-bit count variant) share one stimulus stream and are compared
// every cycle against a queue-style reference model.
module tb_seq_match_event_logger;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = wide instance, 1 = narrow instance.
    int pmod[2] = '{65536, 16};
    int cmax[2] = '{65535, 7};
    int pos_m[2];
    int cnt_m[2];
    int lvl_m[2];
    int ovf_m[2];
    int ent_m[2][DEPTH];

    seq_match_event_logger_if #(.POS_W(16), .CNT_W(16), .DEPTH(DEPTH)) bus_a ();
    seq_match_event_logger_if #(.POS_W(4),  .CNT_W(3),  .DEPTH(DEPTH)) bus_b ();

    seq_match_event_logger #(.POS_W(16), .CNT_W(16), .DEPTH(DEPTH)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seq_match_event_logger #(.POS_W(4), .CNT_W(3), .DEPTH(DEPTH)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos_m[d] = 0;
            cnt_m[d] = 0;
            lvl_m[d] = 0;
            ovf_m[d] = 0;
        end
    endtask

    // Behaviour of one clock edge for instance d, from the logger's rules.
    task automatic model_step(input int d, input bit m, input bit clr, input bit rdy);
        int logged;
        if (clr) begin
            pos_m[d] = 0;
            cnt_m[d] = 0;
            lvl_m[d] = 0;
            ovf_m[d] = 0;
            return;
        end
        logged = pos_m[d];
        if (rdy && lvl_m[d] > 0) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_m[d][i] = ent_m[d][i+1];
            lvl_m[d]--;
        end
        if (m) begin
            if (lvl_m[d] < DEPTH) begin
                ent_m[d][lvl_m[d]] = logged;
                lvl_m[d]++;
            end else begin
                ovf_m[d] = 1;
            end
            if (cnt_m[d] < cmax[d]) cnt_m[d]++;
        end
        pos_m[d] = (pos_m[d] + 1) % pmod[d];
    endtask

    task automatic check_dut(input int d);
        logic [31:0] v, p, l, c, o;
        string nm;
        if (d == 0) begin
            v = 32'(bus_a.rd_valid); p = 32'(bus_a.rd_pos); l = 32'(bus_a.fifo_level);
            c = 32'(bus_a.match_count); o = 32'(bus_a.overflow); nm = "a";
        end else begin
            v = 32'(bus_b.rd_valid); p = 32'(bus_b.rd_pos); l = 32'(bus_b.fifo_level);
            c = 32'(bus_b.match_count); o = 32'(bus_b.overflow); nm = "b";
        end
        check({nm, ".rd_valid"}, v, 32'(lvl_m[d] != 0));
        check({nm, ".fifo_level"}, l, 32'(lvl_m[d]));
        check({nm, ".match_count"}, c, 32'(cnt_m[d]));
        check({nm, ".overflow"}, o, 32'(ovf_m[d]));
        if (lvl_m[d] != 0) check({nm, ".rd_pos"}, p, 32'(ent_m[d][0]));
    endtask

    task automatic drive(input bit m, input bit clr, input bit rdy);
        bus_a.match_in = m; bus_a.clear = clr; bus_a.rd_ready = rdy;
        bus_b.match_in = m; bus_b.clear = clr; bus_b.rd_ready = rdy;
    endtask

    // One cycle: apply inputs, advance model at the edge, compare 1 time unit later.
    task automatic tick(input bit m, input bit clr, input bit rdy);
        drive(m, clr, rdy);
        @(posedge clk);
        model_step(0, m, clr, rdy);
        model_step(1, m, clr, rdy);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        check("reset.rd_pos_a", 32'(bus_a.rd_pos), 32'd0);
        reset = 1'b0;

        // Matches at pos 3 and 6, then two pops.
        for (int i = 0; i < 8; i++) tick(i == 3 || i == 6, 1'b0, 1'b0);
        check("t1.level", 32'(bus_a.fifo_level), 32'd2);
        check("t1.head", 32'(bus_a.rd_pos), 32'd3);
        tick(1'b0, 1'b0, 1'b1);
        check("t1.second", 32'(bus_a.rd_pos), 32'd6);
        tick(1'b0, 1'b0, 1'b1);

        // Six back-to-back pulses at pos 10..15 into a depth-4 FIFO.
        while (pos_m[0] != 10) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
        check("t2.level", 32'(bus_a.fifo_level), 32'd4);
        check("t2.overflow", 32'(bus_a.overflow), 32'd1);
        check("t2.count", 32'(bus_a.match_count), 32'd8);
        check("t2.head", 32'(bus_a.rd_pos), 32'd10);

        // Full FIFO with push and pop together.
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("t3.level", 32'(bus_a.fifo_level), 32'd4);
        check("t3.overflow", 32'(bus_a.overflow), 32'd0);
        check("t3.head", 32'(bus_a.rd_pos), 32'd1);

        // Narrow instance: match at pos 15 and 17 cycles later logs 15 then 0.
        repeat (5) tick(1'b0, 1'b0, 1'b1);
        while (pos_m[1] != 15) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        repeat (16) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("t4.head", 32'(bus_b.rd_pos), 32'd15);
        tick(1'b0, 1'b0, 1'b1);
        check("t4.wrap", 32'(bus_b.rd_pos), 32'd0);

        // Ten pulses with rd_ready high: 3-bit count saturates, no overflow.
        tick(1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b1, 1'b0, 1'b1);
        check("t5.sat", 32'(bus_b.match_count), 32'd7);
        check("t5.ovf", 32'(bus_b.overflow), 32'd0);

        // Clear with a concurrent match and two entries held.
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("t6.level", 32'(bus_a.fifo_level), 32'd0);
        check("t6.count", 32'(bus_a.match_count), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        check("t6.pos0", 32'(bus_a.rd_pos), 32'd0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        model_step(0, 1'b1, 1'b0, 1'b0);
        model_step(1, 1'b1, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        check("rst.rd_valid", 32'(bus_a.rd_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
